// File: rtl/bank2rs_fv_streamer_if.sv
// Bank2RS transmit-side bundle: request channel from the bank controller,
// feature-bank read port, and the framed beat stream into the vertex RS.
// master = the streamer, slave = the surrounding logic (controller/bank/RS).
interface bank2rs_fv_streamer_if #(
   parameter int FV_SIZE     = 16,
   parameter int MAX_FV_NUM  = 16,
   parameter int MAX_NODE_ID = 256,
   parameter int ADDR_W      = 10
);
   localparam int NID_W = $clog2(MAX_NODE_ID);
   localparam int FVN_W = $clog2(MAX_FV_NUM) + 1;

   // request channel
   logic                          req_valid;
   logic                          req_ready;
   logic [NID_W-1:0]              req_node_id;
   logic [ADDR_W-1:0]             req_base;
   logic [FVN_W-1:0]              req_fv_num;
   // RS admission
   logic                          RS_available;
   // feature bank read port
   logic                          mem_rd_en;
   logic [ADDR_W-1:0]             mem_addr;
   logic [2*FV_SIZE-1:0]          mem_rdata;
   // beat stream
   logic                          sos;
   logic                          eos;
   logic [1:0][FV_SIZE-1:0]       FV_data;
   logic [NID_W-1:0]              Node_id;
   logic                          pkt_done;

   modport master (
      input  req_valid, req_node_id, req_base, req_fv_num, RS_available, mem_rdata,
      output req_ready, mem_rd_en, mem_addr, sos, eos, FV_data, Node_id, pkt_done
   );

   modport slave (
      output req_valid, req_node_id, req_base, req_fv_num, RS_available, mem_rdata,
      input  req_ready, mem_rd_en, mem_addr, sos, eos, FV_data, Node_id, pkt_done
   );
endinterface

// File: rtl/bank2rs_fv_streamer.sv
// bank2rs_fv_streamer: reads one node's feature vectors from the feature bank
// (two FVs per bank word) and streams them to the vertex RS as a gap-free
// sos..eos packet, one bank word per beat.
// Optional feature macro: BANK2RS_LEN_CHECK_EN -- illegal FV counts are
// accepted and dropped with a len_err pulse; without it the count is forced
// even and clamped to [4, MAX_FV_NUM].
module bank2rs_fv_streamer #(
   parameter int FV_SIZE     = 16,
   parameter int MAX_FV_NUM  = 16,
   parameter int MAX_NODE_ID = 256,
   parameter int ADDR_W      = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   bank2rs_fv_streamer_if.master bus
`ifdef BANK2RS_LEN_CHECK_EN
   ,
   output logic                  len_err
`endif
);
   localparam int NID_W  = $clog2(MAX_NODE_ID);
   localparam int FVN_W  = $clog2(MAX_FV_NUM) + 1;
   localparam int BEAT_W = $clog2(MAX_FV_NUM / 2) + 1;

   typedef enum logic [1:0] {IDLE, WAIT_RS, STREAM, FLUSH} state_t;

   // Even-ise and clamp an FV count into the supported range, return beats.
   function automatic logic [BEAT_W-1:0] clamp_beats(input logic [FVN_W-1:0] fv);
      logic [FVN_W-1:0] ev;
      ev = {fv[FVN_W-1:1], 1'b0};
      if (ev < FVN_W'(4))
         ev = FVN_W'(4);
      else if (ev > FVN_W'(MAX_FV_NUM))
         ev = FVN_W'(MAX_FV_NUM);
      return BEAT_W'(ev >> 1);
   endfunction

`ifdef BANK2RS_LEN_CHECK_EN
   // An FV count is illegal when odd, below the 2-beat minimum, or too large.
   function automatic logic len_illegal(input logic [FVN_W-1:0] fv);
      return fv[0] || (fv < FVN_W'(4)) || (fv > FVN_W'(MAX_FV_NUM));
   endfunction
`endif

   state_t              state_q, state_d;
   logic                hs, accept;
   logic                rd_en, first_rd, last_rd;
   logic [ADDR_W-1:0]   addr_q;
   logic [BEAT_W-1:0]   rd_cnt_q;
   logic [BEAT_W-1:0]   beats_q;
   logic [NID_W-1:0]    node_q;
   logic                vld_p0, sos_p0, eos_p0;

   assign hs = bus.req_valid && bus.req_ready;
`ifdef BANK2RS_LEN_CHECK_EN
   assign accept = hs && !len_illegal(bus.req_fv_num);
`else
   assign accept = hs;
`endif

   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = rd_en ? addr_q : '0;

   // Next-state and read-issue decode; the first read is issued from WAIT_RS.
   always_comb begin
      state_d  = state_q;
      rd_en    = 1'b0;
      first_rd = 1'b0;
      last_rd  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = WAIT_RS;
         end
         WAIT_RS: begin
            if (bus.RS_available) begin
               rd_en    = 1'b1;
               first_rd = 1'b1;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            rd_en = 1'b1;
            if (rd_cnt_q + BEAT_W'(1) == beats_q) begin
               last_rd = 1'b1;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (bus.eos) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; req_ready is registered so it is low while in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         bus.req_ready <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus.req_ready <= (state_d == IDLE);
      end
   end

   // Read address and issued-read counter; address wraps at 2^ADDR_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q   <= '0;
         rd_cnt_q <= '0;
      end else if (accept) begin
         addr_q   <= bus.req_base;
         rd_cnt_q <= '0;
      end else if (rd_en) begin
         addr_q   <= addr_q + ADDR_W'(1);
         rd_cnt_q <= rd_cnt_q + BEAT_W'(1);
      end
   end

   // Request payload latch; beats stays stable for the whole packet.
   always_ff @(posedge clk) begin
      if (accept) begin
         node_q  <= bus.req_node_id;
         beats_q <= clamp_beats(bus.req_fv_num);
      end
   end

   // ---- stage p0: read in flight, bank data arrives this cycle ----
   // Framing flags travel alongside the outstanding read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p0 <= 1'b0;
         sos_p0 <= 1'b0;
         eos_p0 <= 1'b0;
      end else begin
         vld_p0 <= rd_en;
         sos_p0 <= first_rd;
         eos_p0 <= last_rd;
      end
   end

   // ---- stage p1: output beat registers, zero outside a packet ----
   // Capture bank data into the beat; all outputs clear asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.sos      <= 1'b0;
         bus.eos      <= 1'b0;
         bus.pkt_done <= 1'b0;
         bus.FV_data  <= '0;
         bus.Node_id  <= '0;
      end else begin
         bus.sos      <= vld_p0 && sos_p0;
         bus.eos      <= vld_p0 && eos_p0;
         bus.pkt_done <= vld_p0 && eos_p0;
         bus.FV_data  <= vld_p0 ? bus.mem_rdata : '0;
         bus.Node_id  <= vld_p0 ? node_q : '0;
      end
   end

`ifdef BANK2RS_LEN_CHECK_EN
   // One-cycle error pulse after a dropped illegal request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) len_err <= 1'b0;
      else        len_err <= hs && len_illegal(bus.req_fv_num);
   end
`endif

endmodule

// File: tb/tb_bank2rs_fv_streamer.sv
// Scoreboard bench for bank2rs_fv_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares every beat and every idle cycle.
module tb_bank2rs_fv_streamer;
   localparam int FV_SIZE     = 16;
   localparam int MAX_FV_NUM  = 16;
   localparam int MAX_NODE_ID = 256;
   localparam int ADDR_W      = 10;

   typedef struct packed {
      logic        sos;
      logic        eos;
      logic [7:0]  node;
      logic [15:0] fv1;
      logic [15:0] fv0;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bank2rs_fv_streamer_if #(.FV_SIZE(FV_SIZE), .MAX_FV_NUM(MAX_FV_NUM),
                            .MAX_NODE_ID(MAX_NODE_ID), .ADDR_W(ADDR_W)) bus ();
`ifdef BANK2RS_LEN_CHECK_EN
   logic len_err;
`endif

   bank2rs_fv_streamer #(.FV_SIZE(FV_SIZE), .MAX_FV_NUM(MAX_FV_NUM),
                         .MAX_NODE_ID(MAX_NODE_ID), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
`ifdef BANK2RS_LEN_CHECK_EN
      ,
      .len_err (len_err)
`endif
   );

   beat_t exp_q[$];
   beat_t mon_act, mon_exp;
   int n_chk = 0, n_fail = 0;
   int cyc = 0, rd_total = 0;
   int last_sos_cyc = 0, last_eos_cyc = 0, hs_cyc = 0, rise_cyc = 0, rd0 = 0;
   int beat_idx = 0;
   bit in_pkt = 0, have_eos = 0;

   function automatic logic [31:0] data_of(input logic [9:0] a);
      return {16'h2000 + 16'(a), 16'h1000 + 16'(a)};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rst_n && bus.mem_rd_en) rd_total <= rd_total + 1;
   // bank model: registered read, data derived from the address
   always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= data_of(bus.mem_addr);

   // monitor: compare each beat with the scoreboard, idle cycles against zero
   always @(negedge clk) begin
      if (!rst_n) begin
         in_pkt   = 0;
         have_eos = 0;
      end else if (bus.sos || in_pkt) begin
         mon_act = '{sos: bus.sos, eos: bus.eos, node: bus.Node_id,
                     fv1: bus.FV_data[1], fv0: bus.FV_data[0]};
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            check("beat", 64'(mon_act), 64'(mon_exp));
            check("pkt_done", 64'(bus.pkt_done), 64'(mon_exp.eos));
         end
         check("req_ready_in_pkt", 64'(bus.req_ready), 64'd0);
         if (bus.sos) begin
            if (have_eos) check("sos_gap_ge4", 64'((cyc - last_eos_cyc) >= 4), 64'd1);
            in_pkt       = 1;
            last_sos_cyc = cyc;
            beat_idx     = 0;
         end else begin
            beat_idx++;
         end
         if (bus.eos) begin
            in_pkt       = 0;
            last_eos_cyc = cyc;
            have_eos     = 1;
         end
      end else begin
         check("idle_outputs", {bus.eos, bus.pkt_done, bus.Node_id, bus.FV_data}, 64'd0);
      end
   end

   task automatic push_pkt(input logic [7:0] node, input logic [9:0] base, input int nb);
      logic [9:0]  a;
      logic [31:0] d;
      for (int i = 0; i < nb; i++) begin
         a = base + 10'(i);
         d = data_of(a);
         exp_q.push_back('{sos: (i == 0), eos: (i == nb - 1), node: node,
                           fv1: d[31:16], fv0: d[15:0]});
      end
   endtask

   task automatic do_req(input logic [7:0] node, input logic [9:0] base,
                         input logic [4:0] fvn, input bit keep_valid);
      bit ok;
      ok = 0;
      bus.req_valid   = 1'b1;
      bus.req_node_id = node;
      bus.req_base    = base;
      bus.req_fv_num  = fvn;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            hs_cyc = cyc;
            ok     = 1;
         end
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL handshake_timeout: got no req_ready expected req_ready=1");
      end else begin
         @(posedge clk);
         #1;
      end
      if (!keep_valid) bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !in_pkt) done = 1;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_node_id  = '0;
      bus.req_base     = '0;
      bus.req_fv_num   = '0;
      bus.RS_available = 1'b1;
      bus.mem_rdata    = '0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_outputs", {bus.sos, bus.eos, bus.pkt_done, bus.mem_rd_en,
                              bus.req_ready, bus.Node_id, bus.FV_data}, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("ready_after_reset", 64'(bus.req_ready), 64'd1);

      // minimum packet
      rd0 = rd_total;
      push_pkt(8'd5, 10'h010, 2);
      do_req(8'd5, 10'h010, 5'd4, 0);
      drain();
      check("min_latency", 64'(last_sos_cyc - hs_cyc), 64'd3);
      check("min_reads", 64'(rd_total - rd0), 64'd2);

      // full packet with address wrap
      rd0 = rd_total;
      push_pkt(8'h3A, 10'h3FC, 8);
      do_req(8'h3A, 10'h3FC, 5'd16, 0);
      drain();
      check("full_latency", 64'(last_sos_cyc - hs_cyc), 64'd3);
      check("full_span", 64'(last_eos_cyc - last_sos_cyc), 64'd7);
      check("full_reads", 64'(rd_total - rd0), 64'd8);

      // backpressure, then RS_available drop mid-packet
      bus.RS_available = 1'b0;
      rd0 = rd_total;
      push_pkt(8'h77, 10'h100, 8);
      do_req(8'h77, 10'h100, 5'd16, 0);
      repeat (10) @(posedge clk);
      #1;
      check("no_read_while_wait", 64'(rd_total - rd0), 64'd0);
      rise_cyc = cyc;
      bus.RS_available = 1'b1;
      for (int i = 0; i < 20 && !in_pkt; i++) begin
         @(posedge clk);
         #2;
      end
      bus.RS_available = 1'b0;
      drain();
      bus.RS_available = 1'b1;
      check("bp_sos_delay", 64'(last_sos_cyc - rise_cyc), 64'd2);
      check("bp_reads", 64'(rd_total - rd0), 64'd8);

      // back-to-back with req_valid held high
      rd0 = rd_total;
      push_pkt(8'd10, 10'h200, 2);
      push_pkt(8'd11, 10'h210, 3);
      push_pkt(8'd12, 10'h220, 4);
      push_pkt(8'd13, 10'h230, 2);
      do_req(8'd10, 10'h200, 5'd4, 1);
      do_req(8'd11, 10'h210, 5'd6, 1);
      do_req(8'd12, 10'h220, 5'd8, 1);
      do_req(8'd13, 10'h230, 5'd4, 0);
      drain();
      check("b2b_reads", 64'(rd_total - rd0), 64'd11);

      // asynchronous reset during beat 3 of an 8-beat packet
      push_pkt(8'h42, 10'h300, 8);
      do_req(8'h42, 10'h300, 5'd16, 0);
      for (int i = 0; i < 40 && !(in_pkt && beat_idx == 3); i++) begin
         @(negedge clk);
         #1;
      end
      check("reached_beat3", 64'(in_pkt && beat_idx == 3), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {bus.sos, bus.eos, bus.pkt_done, bus.mem_rd_en,
                                    bus.req_ready, bus.Node_id, bus.FV_data}, 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("ready_after_async_reset", 64'(bus.req_ready), 64'd1);
      rd0 = rd_total;
      push_pkt(8'h09, 10'h050, 3);
      do_req(8'h09, 10'h050, 5'd6, 0);
      drain();
      check("post_reset_latency", 64'(last_sos_cyc - hs_cyc), 64'd3);
      check("post_reset_reads", 64'(rd_total - rd0), 64'd3);

`ifdef BANK2RS_LEN_CHECK_EN
      // illegal length: dropped with a single len_err pulse
      rd0 = rd_total;
      do_req(8'h11, 10'h0A0, 5'd5, 0);
      check("len_err_pulse", 64'(len_err), 64'd1);
      @(posedge clk);
      #1;
      check("len_err_clear", 64'(len_err), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("len_err_no_reads", 64'(rd_total - rd0), 64'd0);
      check("len_err_stays_idle", 64'(bus.req_ready), 64'd1);
`else
      // short and odd lengths are clamped/even-ised
      rd0 = rd_total;
      push_pkt(8'h11, 10'h0A0, 2);
      do_req(8'h11, 10'h0A0, 5'd2, 0);
      drain();
      check("fv2_reads", 64'(rd_total - rd0), 64'd2);
      rd0 = rd_total;
      push_pkt(8'h12, 10'h0B0, 3);
      do_req(8'h12, 10'h0B0, 5'd7, 0);
      drain();
      check("fv7_reads", 64'(rd_total - rd0), 64'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
